// File: rtl/tdm_demux_pkg.sv
// Shared TDM link definitions: FSM encodings and default frame geometry,
// common to the mux (transmit) and demux (receive) sides.
package tdm_demux_pkg;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 8;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  typedef struct packed {
    logic start;  // current bit becomes bit 0 of slot 0
    logic shift;  // ordinary in-frame bit
    logic err;    // framing violation
  } ctrl_t;
endpackage

// File: rtl/tdm_deser.sv
// MSB-first deserialiser. The word output includes the bit being sampled this
// cycle, so a completed word is available in the same cycle as its last bit.
module tdm_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             last,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             done
);
  logic [WIDTH-2:0] sh;

  always_ff @(posedge clk) begin
    if (rst)       sh <= '0;
    else if (load) sh <= (WIDTH-1)'(din);
    else if (en)   sh <= (WIDTH-1)'({sh, din});
  end

  assign word = {sh, din};
  assign done = en & last;
endmodule

// File: rtl/tdm_demux.sv
// TDM link receiver: locks to fsync, counts bits/slots, stages each slot word
// and publishes a whole frame with a one-cycle frame_valid pulse.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  input  logic                      din_valid,
  input  logic                      fsync,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic                      frame_valid,
  output logic                      locked,
  output logic                      sync_err
);
  localparam int BW = $clog2(WIDTH);
  localparam int SW = $clog2(CHANNELS);

  state_t state_q, state_d;
  ctrl_t  ctl;

  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] slot_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0] staging, merged, frame_q;
  logic [WIDTH-1:0] word;
  logic at_start, bit_last, slot_last, word_done, frame_done;

  assign at_start   = (bit_cnt == '0) && (slot_cnt == '0);
  assign bit_last   = (bit_cnt == BW'(WIDTH-1));
  assign slot_last  = (slot_cnt == SW'(CHANNELS-1));
  assign frame_done = word_done & slot_last;

  tdm_deser #(.WIDTH(WIDTH)) u_deser (
    .clk  (clk),
    .rst  (rst),
    .en   (ctl.shift),
    .load (ctl.start),
    .last (bit_last),
    .din  (din),
    .word (word),
    .done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (fsync) begin
            ctl.start = 1'b1;
            state_d   = RECV;
          end
        end
        RECV: begin
          if (at_start && !fsync) begin
            ctl.err = 1'b1;
            state_d = HUNT;
          end else if (fsync && !at_start) begin
            // out-of-place marker: drop the partial frame and resync on this bit
            ctl.err   = 1'b1;
            ctl.start = 1'b1;
          end else begin
            ctl.shift = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    merged = staging;
    merged[CHANNELS-1] = word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      staging     <= '0;
      frame_q     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= ctl.err;
      if (ctl.start) begin
        bit_cnt  <= BW'(1);
        slot_cnt <= '0;
      end else if (ctl.shift) begin
        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
        if (word_done) begin
          staging[slot_cnt] <= word;
          slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
        end
        if (frame_done) begin
          frame_q     <= merged;
          frame_valid <= 1'b1;
        end
      end
    end
  end

  assign ch_data = frame_q;
  assign locked  = (state_q == RECV);
endmodule

// File: tb/tb_tdm_demux.sv
// Randomised scoreboard bench for tdm_demux with a bit-queue reference model.
module tb_tdm_demux;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int FB = CH*W;

  logic          clk = 1'b0;
  logic          rst, din, din_valid, fsync;
  logic [FB-1:0] ch_data;
  logic          frame_valid, locked, sync_err;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fsync(fsync),
    .ch_data(ch_data), .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [FB-1:0] data;
    int            cyc;
  } evt_t;

  evt_t          sb[$];
  bit            m_bits[$];
  bit            m_locked;
  logic [FB-1:0] m_ch;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            mon_en = 0;
  int            drop_pct = 0;

  // Reference: the frame is the list of bits received since the marker.
  task automatic model_step(input bit d, input bit v, input bit fs, input bit r);
    evt_t e;
    if (r) begin
      m_locked = 0; m_bits.delete(); m_ch = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin m_locked = 1; m_bits.delete(); m_bits.push_back(d); end
      end else if (m_bits.size() == 0) begin
        if (fs) m_bits.push_back(d);
        else begin
          e.is_err = 1; e.data = '0; e.cyc = cyc; sb.push_back(e);
          m_locked = 0;
        end
      end else if (fs) begin
        e.is_err = 1; e.data = '0; e.cyc = cyc; sb.push_back(e);
        m_bits.delete(); m_bits.push_back(d);
      end else begin
        m_bits.push_back(d);
      end
      if (m_bits.size() == FB) begin
        e.is_err = 0; e.cyc = cyc; e.data = '0;
        for (int k = 0; k < CH; k++)
          for (int b = 0; b < W; b++)
            e.data[k*W + (W-1-b)] = m_bits[k*W + b];
        sb.push_back(e);
        m_ch = e.data;
        m_bits.delete();
      end
    end
  endtask

  task automatic tick(input bit d, input bit v, input bit fs, input bit r);
    din = d; din_valid = v; fsync = fs; rst = r;
    @(posedge clk);
    cyc++;
    model_step(d, v, fs, r);
    mon_en = 1;
    #1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  // nbits bits of frame f (slot k at [k*W +: W], MSB first); marker on bit 0
  // unless nofs, plus an extra marker at bit fs_bit; stall before stall_bit.
  task automatic send_frame(input logic [FB-1:0] f, input int nbits, input int stall_bit,
                            input int stall_len, input int fs_bit, input bit nofs);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_bit)
        repeat (stall_len) tick(1'($urandom), 1'b0, 1'($urandom), 1'b0);
      while (int'($urandom_range(99)) < drop_pct)
        tick(1'($urandom), 1'b0, 1'($urandom), 1'b0);
      tick(f[(i/W)*W + (W-1) - (i%W)], 1'b1, ((i == 0) && !nofs) || (i == fs_bit), 1'b0);
    end
  endtask

  task automatic check_evt(input bit is_err);
    evt_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s cyc=%0d ch_data=%h expected no pulse",
               is_err ? "sync_err" : "frame_valid", cyc, ch_data);
    end else begin
      e = sb.pop_front();
      if (e.is_err != is_err || e.cyc != cyc || (!is_err && e.data !== ch_data)) begin
        n_fail++;
        $display("FAIL event got %s@%0d data=%h, expected %s@%0d data=%h",
                 is_err ? "sync_err" : "frame", cyc, ch_data,
                 e.is_err ? "sync_err" : "frame", e.cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (locked !== m_locked) begin
        n_fail++;
        $display("FAIL locked cyc=%0d got %b expected %b", cyc, locked, m_locked);
      end
      n_tests++;
      if (ch_data !== m_ch) begin
        n_fail++;
        $display("FAIL ch_data cyc=%0d got %h expected %h", cyc, ch_data, m_ch);
      end
      if (frame_valid === 1'b1) check_evt(1'b0);
      if (sync_err === 1'b1)    check_evt(1'b1);
      if (frame_valid === 1'bx || sync_err === 1'bx) begin
        n_tests++; n_fail++;
        $display("FAIL pulse_x cyc=%0d fv=%b se=%b expected 0/1", cyc, frame_valid, sync_err);
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_tests++; n_fail++;
        $display("FAIL missing_%s cyc=%0d expected at %0d, got no pulse",
                 sb[0].is_err ? "sync_err" : "frame_valid", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [FB-1:0] f;
    int sb_bit, sl, fb;
    bit nf;
    m_locked = 0; m_ch = '0;
    // 1: reset with random inputs
    do_reset(2);
    n_tests++;
    if (ch_data !== '0 || frame_valid !== 0 || locked !== 0 || sync_err !== 0) begin
      n_fail++;
      $display("FAIL reset_state got ch=%h fv=%b lk=%b se=%b expected all 0",
               ch_data, frame_valid, locked, sync_err);
    end
    repeat (3) tick(1'($urandom), 1'b1, 1'b0, 1'b0);
    // 2: clean frame
    send_frame(32'h01FF3CA5, FB, -1, 0, -1, 0);
    // 3: same frame, 3-cycle stall mid slot 2
    send_frame(32'h01FF3CA5, FB, 19, 3, -1, 0);
    // 4: marker at slot 1 bit 4 resyncs; following frame decodes
    send_frame(32'hDEADBEEF, 12, -1, 0, -1, 0);
    send_frame(32'h44332211, FB, -1, 0, -1, 0);
    // 5: frame without marker drops lock; relock on next marker
    send_frame(32'h55555555, FB, -1, 0, -1, 1);
    send_frame(32'h03020100, FB, -1, 0, -1, 0);
    // 6: reset mid-frame at slot 2 bit 5, then a clean frame
    send_frame(32'hCAFEF00D, 21, -1, 0, -1, 0);
    do_reset(1);
    send_frame(32'h87654321, FB, -1, 0, -1, 0);
    // marker on the very last bit position aborts that frame
    send_frame(32'h12345678, FB, -1, 0, FB-1, 0);
    send_frame(32'h9ABCDEF0, FB-1, -1, 0, -1, 1);
    send_frame(32'h0F1E2D3C, FB, -1, 0, -1, 0);
    // randomised frames with stalls, stray markers and missing markers
    drop_pct = 15;
    for (int n = 0; n < 60; n++) begin
      f      = FB'({$urandom, $urandom});
      sb_bit = int'($urandom_range(FB-1));
      sl     = int'($urandom_range(3));
      fb     = ($urandom_range(9) == 0) ? int'($urandom_range(FB-1, 1)) : -1;
      nf     = ($urandom_range(14) == 0);
      send_frame(f, FB, sb_bit, sl, fb, nf);
      if ($urandom_range(19) == 0) repeat ($urandom_range(5)) tick(1'($urandom), 1'b1, 1'b0, 1'b0);
    end
    drop_pct = 0;
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending events expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
